// File: rtl/collision_scan_ctrl.sv
// Frame-synchronous collision scanner and game-state controller for the Asteroids datapath.
// Scans one rock/target pair per clock from a per-frame snapshot, then commits pulses, score and lives.
module collision_scan_ctrl #(
    parameter int N_ROCKS        = 4,
    parameter int N_SHOTS        = 4,
    parameter int COORD_W        = 10,
    parameter int SHIP_R         = 48,
    parameter int SHOT_R         = 32,
    parameter int RELEASE_FRAMES = 180,
    parameter int LIVES          = 3,
    parameter int SCORE_W        = 16,
    parameter int SCORE_PER_HIT  = 10
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         frame_tick,
    input  logic [COORD_W-1:0]           ship_x,
    input  logic [COORD_W-1:0]           ship_y,
    input  logic [N_ROCKS*COORD_W-1:0]   rock_x,
    input  logic [N_ROCKS*COORD_W-1:0]   rock_y,
    input  logic [N_SHOTS*COORD_W-1:0]   shot_x,
    input  logic [N_SHOTS*COORD_W-1:0]   shot_y,
    input  logic [N_SHOTS-1:0]           shot_active,
    output logic [N_ROCKS-1:0]           rock_hold,
    output logic [N_ROCKS-1:0]           reset_rocks,
    output logic [N_SHOTS-1:0]           reset_shots,
    output logic                         reset_ship,
    output logic                         hit,
    output logic [3:0]                   lives,
    output logic [SCORE_W-1:0]           score,
    output logic                         game_over,
    output logic                         busy,
    output logic                         overrun
);

    localparam int RW    = (N_ROCKS > 1) ? $clog2(N_ROCKS) : 1;
    localparam int TW    = $clog2(N_SHOTS + 1);
    localparam int CW    = (RELEASE_FRAMES > 1) ? $clog2(RELEASE_FRAMES) : 1;
    localparam int SUM_W = SCORE_W + 32;
    localparam logic [COORD_W:0] R_SHIP = (COORD_W + 1)'(SHIP_R);
    localparam logic [COORD_W:0] R_SHOT = (COORD_W + 1)'(SHOT_R);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT} state_t;

    state_t                       state_q;
    logic [RW-1:0]                r_idx_q;
    logic [TW-1:0]                t_idx_q;
    logic [COORD_W-1:0]           ship_x_q, ship_y_q;
    logic [N_ROCKS*COORD_W-1:0]   rock_x_q, rock_y_q;
    logic [N_SHOTS*COORD_W-1:0]   shot_x_q, shot_y_q;
    logic [N_SHOTS-1:0]           act_q;
    logic [N_ROCKS-1:0]           hold_s_q;
    logic [N_ROCKS-1:0]           rock_flag_q;
    logic [N_SHOTS-1:0]           shot_flag_q;
    logic                         ship_flag_q;
    logic [TW-1:0]                hit_cnt_q;
    logic [CW-1:0]                rel_cnt_q;
    logic [N_ROCKS-1:0]           rock_hold_q, reset_rocks_q;
    logic [N_SHOTS-1:0]           reset_shots_q;
    logic                         reset_ship_q, hit_q, game_over_q, busy_q, overrun_q;
    logic [3:0]                   lives_q;
    logic [SCORE_W-1:0]           score_q;

    logic [COORD_W-1:0]           rx, ry, tx, ty;
    logic [TW-1:0]                shot_sel;
    logic [COORD_W:0]             dx, dy, adx, ady, radius;
    logic                         tgt_ok, pair_hit;
    logic [SUM_W-1:0]             score_sum;
    logic [SCORE_W-1:0]           score_d;
    logic [3:0]                   lives_d;

    // Target index 0 is the ship; 1..N_SHOTS map to shot channels 0..N_SHOTS-1.
    always_comb begin
        rx       = rock_x_q[r_idx_q*COORD_W +: COORD_W];
        ry       = rock_y_q[r_idx_q*COORD_W +: COORD_W];
        shot_sel = t_idx_q - TW'(1);
        if (t_idx_q == '0) begin
            tx     = ship_x_q;
            ty     = ship_y_q;
            radius = R_SHIP;
            tgt_ok = 1'b1;
        end else begin
            tx     = shot_x_q[shot_sel*COORD_W +: COORD_W];
            ty     = shot_y_q[shot_sel*COORD_W +: COORD_W];
            radius = R_SHOT;
            tgt_ok = act_q[shot_sel] && !shot_flag_q[shot_sel];
        end
        dx       = {1'b0, rx} - {1'b0, tx};
        dy       = {1'b0, ry} - {1'b0, ty};
        adx      = dx[COORD_W] ? -dx : dx;
        ady      = dy[COORD_W] ? -dy : dy;
        pair_hit = !hold_s_q[r_idx_q] && !rock_flag_q[r_idx_q] && tgt_ok
                   && (adx <= radius) && (ady <= radius);
    end

    always_comb begin
        score_sum = SUM_W'(score_q) + SUM_W'(hit_cnt_q) * SUM_W'(SCORE_PER_HIT);
        score_d   = (|score_sum[SUM_W-1:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
        lives_d   = (ship_flag_q && lives_q != 4'd0) ? lives_q - 4'd1 : lives_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= ST_IDLE;
            r_idx_q       <= '0;
            t_idx_q       <= '0;
            ship_x_q      <= '0;
            ship_y_q      <= '0;
            rock_x_q      <= '0;
            rock_y_q      <= '0;
            shot_x_q      <= '0;
            shot_y_q      <= '0;
            act_q         <= '0;
            hold_s_q      <= '0;
            rock_flag_q   <= '0;
            shot_flag_q   <= '0;
            ship_flag_q   <= 1'b0;
            hit_cnt_q     <= '0;
            rel_cnt_q     <= '0;
            rock_hold_q   <= '1;
            reset_rocks_q <= '0;
            reset_shots_q <= '0;
            reset_ship_q  <= 1'b0;
            hit_q         <= 1'b0;
            lives_q       <= 4'(LIVES);
            score_q       <= '0;
            game_over_q   <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            reset_rocks_q <= '0;
            reset_shots_q <= '0;
            reset_ship_q  <= 1'b0;
            hit_q         <= 1'b0;

            // Release pacing runs off every tick regardless of the scan FSM.
            if (game_over_q) begin
                rock_hold_q <= '1;
                rel_cnt_q   <= '0;
            end else if (frame_tick && rock_hold_q != '0) begin
                if (rel_cnt_q == CW'(RELEASE_FRAMES - 1)) begin
                    rel_cnt_q   <= '0;
                    rock_hold_q <= rock_hold_q & (rock_hold_q - N_ROCKS'(1));
                end else begin
                    rel_cnt_q <= rel_cnt_q + CW'(1);
                end
            end

            if (frame_tick && !game_over_q && state_q != ST_IDLE)
                overrun_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (frame_tick && !game_over_q) begin
                        ship_x_q <= ship_x;
                        ship_y_q <= ship_y;
                        rock_x_q <= rock_x;
                        rock_y_q <= rock_y;
                        shot_x_q <= shot_x;
                        shot_y_q <= shot_y;
                        act_q    <= shot_active;
                        hold_s_q <= rock_hold_q;
                        r_idx_q  <= '0;
                        t_idx_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (pair_hit) begin
                        rock_flag_q[r_idx_q] <= 1'b1;
                        if (t_idx_q == '0) begin
                            ship_flag_q <= 1'b1;
                        end else begin
                            shot_flag_q[shot_sel] <= 1'b1;
                            hit_cnt_q             <= hit_cnt_q + TW'(1);
                        end
                    end
                    if (t_idx_q == TW'(N_SHOTS)) begin
                        t_idx_q <= '0;
                        if (r_idx_q == RW'(N_ROCKS - 1)) begin
                            r_idx_q <= '0;
                            state_q <= ST_COMMIT;
                        end else begin
                            r_idx_q <= r_idx_q + RW'(1);
                        end
                    end else begin
                        t_idx_q <= t_idx_q + TW'(1);
                    end
                end
                ST_COMMIT: begin
                    reset_rocks_q <= rock_flag_q;
                    reset_shots_q <= shot_flag_q;
                    reset_ship_q  <= ship_flag_q;
                    hit_q         <= (hit_cnt_q != '0);
                    score_q       <= score_d;
                    lives_q       <= lives_d;
                    if (lives_d == 4'd0) begin
                        game_over_q <= 1'b1;
                        rock_hold_q <= '1;
                        rel_cnt_q   <= '0;
                    end
                    rock_flag_q <= '0;
                    shot_flag_q <= '0;
                    ship_flag_q <= 1'b0;
                    hit_cnt_q   <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rock_hold   = rock_hold_q;
    assign reset_rocks = reset_rocks_q;
    assign reset_shots = reset_shots_q;
    assign reset_ship  = reset_ship_q;
    assign hit         = hit_q;
    assign lives       = lives_q;
    assign score       = score_q;
    assign game_over   = game_over_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_collision_scan_ctrl.sv
// Self-checking bench for collision_scan_ctrl: random and directed frames against a frame-level reference model.
module tb_collision_scan_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  ship_x = '0, ship_y = '0;
    logic [39:0] rock_x = '0, rock_y = '0, shot_x = '0, shot_y = '0;
    logic [3:0]  shot_active = '0;
    logic [3:0]  rock_hold, reset_rocks, reset_shots;
    logic        reset_ship, hit, game_over, busy, overrun;
    logic [3:0]  lives;
    logic [15:0] score;

    always #5 Clk = ~Clk;

    collision_scan_ctrl #(
        .N_ROCKS(4), .N_SHOTS(4), .COORD_W(10), .SHIP_R(48), .SHOT_R(32),
        .RELEASE_FRAMES(180), .LIVES(3), .SCORE_W(16), .SCORE_PER_HIT(10)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .ship_x(ship_x), .ship_y(ship_y),
        .rock_x(rock_x), .rock_y(rock_y),
        .shot_x(shot_x), .shot_y(shot_y), .shot_active(shot_active),
        .rock_hold(rock_hold), .reset_rocks(reset_rocks), .reset_shots(reset_shots),
        .reset_ship(reset_ship), .hit(hit), .lives(lives), .score(score),
        .game_over(game_over), .busy(busy), .overrun(overrun)
    );

    int n_cmp = 0, n_err = 0;
    int rx[4], ry[4], sx[4], sy[4];
    int shx, shy;
    logic [3:0] act;
    int m_ticks, m_lives, m_score;
    bit m_go, m_ovr;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit near(input int ax, input int ay, input int bx, input int by, input int r);
        return (iabs(ax - bx) <= r) && (iabs(ay - by) <= r);
    endfunction

    // Rocks are released lowest-first, one per 180 counted ticks.
    function automatic logic [3:0] model_hold();
        logic [3:0] h;
        int k;
        h = 4'hF;
        if (m_go) return h;
        k = m_ticks / 180;
        if (k > 4) k = 4;
        h = h << k;
        return h;
    endfunction

    task automatic model_reset();
        m_ticks = 0; m_lives = 3; m_score = 0; m_go = 0; m_ovr = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            rock_x[i*10 +: 10] = 10'(rx[i]);
            rock_y[i*10 +: 10] = 10'(ry[i]);
            shot_x[i*10 +: 10] = 10'(sx[i]);
            shot_y[i*10 +: 10] = 10'(sy[i]);
        end
        ship_x = 10'(shx);
        ship_y = 10'(shy);
        shot_active = act;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hold"}, rock_hold, 4'hF);
        chk({tag, "_pulses"}, {reset_rocks, reset_shots, reset_ship, hit}, 0);
        chk({tag, "_lives"}, lives, 3);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_flags"}, {game_over, busy, overrun}, 0);
    endtask

    task automatic run_frame(input string tag);
        logic [3:0] hold0, e_rk, e_sh;
        bit e_ship;
        int hits;
        hold0 = model_hold();
        e_rk = '0; e_sh = '0; e_ship = 0; hits = 0;
        for (int r = 0; r < 4; r++) begin
            if (!hold0[r]) begin
                if (near(rx[r], ry[r], shx, shy, 48)) begin
                    e_rk[r] = 1'b1;
                    e_ship = 1;
                end else begin
                    for (int s = 0; s < 4; s++) begin
                        if (act[s] && !e_sh[s] && near(rx[r], ry[r], sx[s], sy[s], 32)) begin
                            e_rk[r] = 1'b1;
                            e_sh[s] = 1'b1;
                            hits++;
                            break;
                        end
                    end
                end
            end
        end
        drive();
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        if (!m_go) m_ticks++;
        chk({tag, "_busy_start"}, busy, 1);
        chk({tag, "_hold_tick"}, rock_hold, model_hold());
        repeat (20) @(posedge Clk);
        #1;
        chk({tag, "_early_pulse"}, {reset_rocks, reset_shots, reset_ship, hit, busy}, 1);
        @(posedge Clk); #1;
        m_score = m_score + hits * 10;
        if (m_score > 65535) m_score = 65535;
        if (e_ship && m_lives > 0) m_lives--;
        if (m_lives == 0) m_go = 1;
        chk({tag, "_rocks"}, reset_rocks, e_rk);
        chk({tag, "_shots"}, reset_shots, e_sh);
        chk({tag, "_ship"}, reset_ship, e_ship);
        chk({tag, "_hit"}, hit, hits != 0);
        chk({tag, "_lives"}, lives, m_lives);
        chk({tag, "_score"}, score, m_score);
        chk({tag, "_gover"}, game_over, m_go);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_overrun"}, overrun, m_ovr);
        chk({tag, "_hold"}, rock_hold, model_hold());
        @(posedge Clk); #1;
        chk({tag, "_pulse_len"}, {reset_rocks, reset_shots, reset_ship, hit}, 0);
    endtask

    task automatic far_frame();
        shx = 1010; shy = 1010;
        for (int i = 0; i < 4; i++) begin
            rx[i] = $urandom_range(0, 900);
            ry[i] = $urandom_range(0, 900);
            sx[i] = $urandom_range(0, 1023);
            sy[i] = $urandom_range(0, 1023);
        end
        act = 4'($urandom);
    endtask

    task automatic near_frame();
        int k;
        far_frame();
        for (int i = 0; i < 4; i++) begin
            k = $urandom_range(0, 3);
            sx[i] = rx[k] + $urandom_range(0, 68) - 34;
            sy[i] = ry[k] + $urandom_range(0, 68) - 34;
            if (sx[i] < 0) sx[i] = 0;
            if (sy[i] < 0) sy[i] = 0;
        end
    endtask

    task automatic quiet_frame();
        shx = 1010; shy = 1010;
        rx[0] = 600; ry[0] = 100; rx[1] = 600; ry[1] = 300;
        rx[2] = 600; ry[2] = 500; rx[3] = 600; ry[3] = 700;
        for (int i = 0; i < 4; i++) begin sx[i] = 0; sy[i] = 1000; end
        act = 4'h0;
    endtask

    task automatic release_phase(input int n);
        for (int f = 0; f < n; f++) begin
            far_frame();
            run_frame("rel");
        end
    endtask

    initial begin
        int any;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk_reset_vals("rst");
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        release_phase(725);
        chk("rel_done", rock_hold, 0);
        for (int f = 0; f < 40; f++) begin
            near_frame();
            run_frame("near");
        end

        // Underflow near the screen origin: shot0 (10,10) vs rock2 (0,0).
        quiet_frame();
        rx[2] = 0; ry[2] = 0; sx[0] = 10; sy[0] = 10; act = 4'b0001;
        any = m_score;
        run_frame("edge");
        chk("edge_delta", score - any, 10);

        // Two shots on rock1: only the lower-numbered one retires; inactive shot2 on rock3 ignored.
        quiet_frame();
        rx[1] = 300; ry[1] = 300; sx[0] = 310; sy[0] = 300; sx[1] = 290; sy[1] = 300;
        sx[2] = rx[3]; sy[2] = ry[3]; act = 4'b0011;
        run_frame("one2one");
        chk("one2one_shots", reset_shots, 0);

        // Reset in the middle of a scan that would otherwise hit.
        quiet_frame();
        rx[0] = 200; ry[0] = 200; sx[0] = 205; sy[0] = 205; act = 4'b0001;
        drive();
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        repeat (7) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        model_reset();
        any = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge Clk); #1;
            if ({reset_rocks, reset_shots, reset_ship, hit, busy} != 0) any = 1;
        end
        chk("midrst_quiet", any, 0);
        chk("midrst_score", score, 0);

        release_phase(720);

        quiet_frame();
        shx = 100; shy = 100; rx[0] = 148; ry[0] = 52;
        run_frame("ship_in");
        chk("ship_in_lives", lives, 2);
        quiet_frame();
        shx = 100; shy = 100; rx[0] = 149; ry[0] = 100;
        run_frame("ship_out");

        // Second tick 5 cycles after the first is dropped.
        quiet_frame();
        drive();
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        m_ticks++;
        repeat (4) @(posedge Clk);
        #1;
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        m_ticks++;
        m_ovr = 1;
        chk("ovr_set", overrun, 1);
        repeat (15) @(posedge Clk);
        #1;
        chk("ovr_commit_busy", busy, 1);
        @(posedge Clk); #1;
        chk("ovr_commit_end", busy, 0);
        any = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge Clk); #1;
            if (busy) any = 1;
        end
        chk("ovr_no_rescan", any, 0);

        quiet_frame();
        shx = 100; shy = 100; rx[0] = 120; ry[0] = 120; rx[1] = 80; ry[1] = 80;
        run_frame("two_rocks");
        chk("two_rocks_lives", lives, 1);
        quiet_frame();
        shx = 100; shy = 100; rx[0] = 100; ry[0] = 100;
        run_frame("last_life");
        chk("go_hold", rock_hold, 4'hF);

        far_frame();
        drive();
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        any = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge Clk); #1;
            if (busy || hit) any = 1;
        end
        chk("go_ignored", any, 0);
        chk("go_level", game_over, 1);
        chk("go_score", score, m_score);
        chk("go_hold2", rock_hold, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/collision_scan_ctrl.md
# collision_scan_ctrl

Parametrised, clocked collision and game-state controller for the Asteroids datapath. On each frame tick it snapshots the ship, rock and shot positions. It then scans every rock against the ship and every active shot sequentially, one pair per clock, and issues one-cycle respawn pulses to the rock, shot and ship movers. It also owns staggered rock release, lives, score and game-over, and replaces the unclocked single-configuration collision logic.

## Interface
Parameters:
- N_ROCKS, 4: number of rock channels (1..8).
- N_SHOTS, 4: number of shot channels (1..8).
- COORD_W, 10: width of every x/y coordinate.
- SHIP_R, 48: ship–rock hit half-extent, in pixels.
- SHOT_R, 32: shot–rock hit half-extent, in pixels.
- RELEASE_FRAMES, 180: frame ticks between successive rock releases (3 s at 60 Hz).
- LIVES, 3: initial lives (1..15).
- SCORE_W, 16: score width.
- SCORE_PER_HIT, 10: points per shot hit.

Ports:
- Clk, in, 1: system clock. All state is updated on the rising edge.
- Reset_n, in, 1: asynchronous active-low reset.
- frame_tick, in, 1: single-cycle pulse, one per frame, derived from vs.
- ship_x, ship_y, in, COORD_W each: ship centre.
- rock_x, rock_y, in, N_ROCKS*COORD_W each: packed rock centres; channel i occupies bits [i*COORD_W +: COORD_W].
- shot_x, shot_y, in, N_SHOTS*COORD_W each: packed shot centres.
- shot_active, in, N_SHOTS: a shot takes part in the scan only if its bit is 1.
- rock_hold, out, N_ROCKS: level. 1 means the rock is withheld (not yet released).
- reset_rocks, out, N_ROCKS: one-cycle respawn pulse per rock.
- reset_shots, out, N_SHOTS: one-cycle retire pulse per shot.
- reset_ship, out, 1: one-cycle ship respawn pulse.
- hit, out, 1: one-cycle pulse; at least one shot hit this frame.
- lives, out, 4: remaining lives.
- score, out, SCORE_W: accumulated score.
- game_over, out, 1: level; asserted when lives reaches 0.
- busy, out, 1: a scan or commit is in progress.
- overrun, out, 1: sticky; a frame_tick arrived while busy.

## Operation
- Reset values:
  - rock_hold = all 1.
  - All pulses = 0; busy = 0; overrun = 0; game_over = 0.
  - lives = LIVES; score = 0.
  - Release counter = 0; FSM in IDLE.
- FSM states are IDLE, SCAN and COMMIT.
  - IDLE to SCAN: frame_tick && !game_over. The edge that makes this transition latches all positions, shot_active and rock_hold into snapshot registers.
  - SCAN visits rock r = 0..N_ROCKS-1 (outer loop). For each rock it visits target t = ship, then shot 0..N_SHOTS-1 (inner loop), one pair per cycle, for N_ROCKS*(N_SHOTS+1) cycles.
  - SCAN to COMMIT occurs after the last pair. COMMIT lasts 1 cycle, then the FSM returns to IDLE.
- Pair eligibility:
  - The rock must not be held in the snapshot and must not already be flagged this frame.
  - A shot target must be active and not already flagged this frame.
  - Consequence: each rock is killed by at most one object and each shot kills at most one rock. The ship may hit several rocks.
- Overlap test: |rock_x - tx| <= R and |rock_y - ty| <= R, where R = SHIP_R or SHOT_R.
  - Differences are computed in COORD_W+1 bits, signed, so there is no wrap-around at screen edges near 0.
  - Comparisons are inclusive.
- On an eligible overlap, set the rock flag. Also set the ship flag or the corresponding shot flag, and increment the hit count (shots only).
- COMMIT actions:
  - reset_rocks = rock flags, reset_shots = shot flags, reset_ship = ship flag.
  - hit = (hit count != 0).
  - score += hit count * SCORE_PER_HIT, saturating at 2^SCORE_W - 1.
  - If the ship flag is set, lives decrements by exactly 1 (once per frame), saturating at 0.
  - game_over sets when lives becomes 0.
  - All flags clear.
- Rock release:
  - Every frame_tick while !game_over and rock_hold != 0 increments the release counter.
  - When the counter reaches RELEASE_FRAMES-1, it wraps to 0 and the lowest set bit of rock_hold clears.
  - The counter freezes once rock_hold = 0.
  - This runs independently of the FSM. A release during SCAN takes effect on the next frame, because the scan uses the snapshot.
- Game over:
  - rock_hold is forced to all 1 and the release counter to 0.
  - frame_tick is ignored.
  - An in-flight scan still completes its COMMIT. Score stays frozen after that commit.
  - Only Reset_n leaves the game-over state.
- A frame_tick seen in SCAN or COMMIT is dropped and sets overrun. Release counting still uses that tick.
- Reset_n asserted mid-scan aborts the scan immediately. All outputs return to their reset values, and no pulse is emitted.

## Timing
- All outputs are registered.
- With frame_tick sampled high at edge E0:
  - busy = 1 from E0 through the COMMIT cycle.
  - Pulses are high for exactly the one COMMIT cycle, from edge E0 + N_ROCKS*(N_SHOTS+1) + 1; with defaults this is E0 + 21.
  - lives, score and game_over update at the same edge as the pulses.
- The minimum frame_tick spacing without overrun is N_ROCKS*(N_SHOTS+1) + 2 cycles.
- rock_hold changes at the edge that samples the releasing frame_tick.

## Test plan
- Release: after reset, apply 180 frame_ticks → rock_hold goes from 1111 to 1110 on the 180th tick, 1100 on the 360th, and 0000 on the 720th. No further change after 720.
- Ship boundary: ship (100,100), rock0 released at (148,52) → reset_ship = 1, reset_rocks = 0001, lives 3 to 2. Repeat with rock0 at (149,100) → no pulses.
- Edge underflow: shot0 active at (10,10), rock2 released at (0,0) → reset_rocks = 0100, reset_shots = 0001, hit = 1, score = 10, all 21 cycles after the tick.
- One-to-one: shots 0 and 1 both overlapping rock1 → only shot0 retired, score += 10. Inactive shot2 overlapping rock3 → no pulse.
- Lives/game over: ship hit by 2 rocks in the same frame → lives drops by 1 only. Three hit frames → lives = 0 and game_over = 1, rock_hold = 1111, later ticks ignored.
- Overrun/reset: a tick 5 cycles after a prior tick → overrun = 1 and no extra scan. Assert Reset_n low mid-scan → no pulses, all outputs at reset values.
